// File: rtl/country_road_sensor.sv
// ---------------------------------------------------------------------------
// country_road_sensor
//
// Vehicle-detector front end for the highway / country-road intersection
// controller. Cleans up the raw inductive-loop level, counts country-road
// vehicles that arrive, retires them while the country road shows green, and
// raises the controller's car-present request `x` while anyone is waiting.
// It also watches the controller's own light outputs and latches a sticky
// flag if they ever show an illegal combination.
//
// Light encoding (both roads): 00 red, 01 yellow, 10 green, 11 illegal.
//
// Ports:
//   clk           in   1   clock, all state updates on the rising edge
//   rst           in   1   synchronous, active-high reset
//   loop_raw      in   1   asynchronous raw loop level, 1 = vehicle on loop
//   highway       in   2   controller highway light
//   country_road  in   2   controller country-road light
//   x             out  1   registered vehicle-waiting request
//   queue_count   out  QW  registered count of waiting vehicles (saturating)
//   conflict      out  1   sticky registered illegal-light flag
//
// Parameters:
//   DEBOUNCE_CYCLES   cycles the synchronized level must disagree with the
//                     debounced level before the debounced level flips (>=1)
//   DEPART_CYCLES     country-green cycles per vehicle departure (>=1)
//   QW                queue counter width
//   MAX_GREEN_CYCLES  country-green budget, used only with CR_MAX_GREEN_EN
//
// Build option:
//   CR_MAX_GREEN_EN   when defined, a green timer caps each country-green
//                     service at MAX_GREEN_CYCLES and then withdraws the
//                     request so the highway gets a turn. When undefined the
//                     country road keeps green for as long as cars remain.
//
// Every output comes straight from a flop; no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module country_road_sensor #(
   parameter int DEBOUNCE_CYCLES  = 4,
   parameter int DEPART_CYCLES    = 3,
   parameter int QW               = 4,
   parameter int MAX_GREEN_CYCLES = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          loop_raw,
   input  logic [1:0]    highway,
   input  logic [1:0]    country_road,
   output logic          x,
   output logic [QW-1:0] queue_count,
   output logic          conflict
);

   localparam int SW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int DW = $clog2(DEPART_CYCLES + 1);
   localparam logic [QW-1:0] QMAX = {QW{1'b1}};

   localparam logic [1:0] RED   = 2'b00;
   localparam logic [1:0] GREEN = 2'b10;
   localparam logic [1:0] BAD   = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,     // nobody waiting, no request
      S_WAIT,     // vehicles waiting, request raised
      S_SERVE,    // country green, vehicles leaving
      S_HOLDOFF   // request withdrawn until the country road is red again
   } state_t;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic          sync1_q, sync2_q;
   logic          deb_q, deb_d;
   logic          deb_prev_q;
   logic [SW-1:0] stab_q, stab_d;
   logic          arrival_q;
   logic [DW-1:0] dep_q, dep_d;
   logic [QW-1:0] queue_q, queue_d;
   state_t        state_q, state_d;
   logic          x_q;
   logic          conflict_q, conflict_d;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic illegal;
   logic cr_green;
   logic counting;
   logic dep_wrap;
   logic depart;
   logic green_expired;

   // Any simultaneous non-red pair, or an 11 code on either road, is illegal.
   assign illegal = (highway == BAD) || (country_road == BAD) ||
                    ((highway != RED) && (country_road != RED));

   // The flag must act in the very cycle the bad lights are seen, so the rest
   // of the logic looks at the next value rather than the registered one.
   assign conflict_d = conflict_q | illegal;

   assign cr_green = (country_road == GREEN);

   // Service time only accrues while we are actually serving on green and the
   // lights are sane.
   assign counting = (state_q == S_SERVE) && cr_green && !conflict_d;
   assign dep_wrap = counting && (dep_q == DW'(DEPART_CYCLES - 1));
   assign depart   = dep_wrap && (queue_q != '0);

   // ------------------------------------------------------------------------
   // Debounce: flip only after DEBOUNCE_CYCLES consecutive disagreements
   // ------------------------------------------------------------------------
   // NOTE: every variable written in an always_comb gets a default first, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      deb_d  = deb_q;
      stab_d = '0;
      if (sync2_q != deb_q) begin
         if (stab_q == SW'(DEBOUNCE_CYCLES - 1)) begin
            deb_d  = sync2_q;
            stab_d = '0;
         end else begin
            stab_d = stab_q + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Departure timer: wraps every DEPART_CYCLES green cycles; frozen while a
   // conflict is flagged, cleared whenever we are not serving on green.
   // ------------------------------------------------------------------------
   always_comb begin
      dep_d = dep_q;
      if (!conflict_d) begin
         if (counting) begin
            dep_d = dep_wrap ? '0 : dep_q + 1'b1;
         end else begin
            dep_d = '0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Queue arithmetic: saturating up, never below zero, arrival and departure
   // in the same cycle cancel.
   // ------------------------------------------------------------------------
   always_comb begin
      queue_d = queue_q;
      if (arrival_q && !depart) begin
         if (queue_q != QMAX) begin
            queue_d = queue_q + 1'b1;
         end
      end else if (depart && !arrival_q) begin
         queue_d = queue_q - 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Optional green budget
   // ------------------------------------------------------------------------
`ifdef CR_MAX_GREEN_EN
   localparam int GW = $clog2(MAX_GREEN_CYCLES + 1);

   logic [GW-1:0] green_q, green_d;

   always_comb begin
      green_d = green_q;
      if (!conflict_d) begin
         green_d = counting ? green_q + 1'b1 : '0;
      end
   end

   assign green_expired = counting && (green_q == GW'(MAX_GREEN_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         green_q <= '0;
      end else begin
         green_q <= green_d;
      end
   end
`else
   // Without the budget the green service never times out.
   logic unused_max_green;
   assign unused_max_green = (MAX_GREEN_CYCLES > 0);
   assign green_expired    = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Next state
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      if (!conflict_d) begin
         unique case (state_q)
            S_IDLE: begin
               if (queue_q != '0) state_d = S_WAIT;
            end
            S_WAIT: begin
               if (cr_green) state_d = S_SERVE;
            end
            S_SERVE: begin
               // Drop the request on the same edge the last car leaves, or
               // when the green budget runs out with cars still queued.
               if ((depart && (queue_d == '0)) || green_expired) begin
                  state_d = S_HOLDOFF;
               end else if (!cr_green) begin
                  state_d = (queue_q != '0) ? S_WAIT : S_HOLDOFF;
               end
            end
            S_HOLDOFF: begin
               // Stay quiet through country yellow; re-arm only once the
               // country road is red and the highway has been given the road.
               if ((country_road == RED) && (highway != RED)) begin
                  state_d = (queue_q != '0) ? S_WAIT : S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      // NOTE: the reset is synchronous; every flop here is plain control
      // state and is cleared, so a mid-run reset also discards the queue.
      if (rst) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         deb_q      <= 1'b0;
         deb_prev_q <= 1'b0;
         stab_q     <= '0;
         arrival_q  <= 1'b0;
         dep_q      <= '0;
         queue_q    <= '0;
         state_q    <= S_IDLE;
         x_q        <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         // Two-flop synchronizer for the asynchronous loop level.
         sync1_q    <= loop_raw;
         sync2_q    <= sync1_q;

         deb_q      <= deb_d;
         stab_q     <= stab_d;
         deb_prev_q <= deb_q;
         // One-cycle pulse on each debounced rising edge.
         arrival_q  <= deb_q & ~deb_prev_q;

         dep_q      <= dep_d;
         queue_q    <= queue_d;
         state_q    <= state_d;
         conflict_q <= conflict_d;

         // Request is decoded from the next state so it moves on the same
         // edge as the transition; a conflict always silences it.
         x_q <= !conflict_d && ((state_d == S_WAIT) || (state_d == S_SERVE));
      end
   end

   assign x           = x_q;
   assign queue_count = queue_q;
   assign conflict    = conflict_q;

endmodule

// File: doc/country_road_sensor.md
Name: country_road_sensor

Overview:
- Vehicle-detector front end for the highway/country-road intersection controller.
- Consumes the raw inductive-loop pulse and the controller's two light outputs, and keeps a count of waiting country-road vehicles.
- Produces the controller's car-present request `x`: raised while vehicles wait, dropped once the queue drains during country green.
- Also flags illegal light combinations driven by the controller.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles the synchronized loop level must differ from the debounced level before the debounced level flips (≥1).
- DEPART_CYCLES, 3: country-green cycles per vehicle departure (≥1).
- QW, 4: queue counter width; saturates at 2^QW-1.
- MAX_GREEN_CYCLES, 16: country-green cycle budget; used only with CR_MAX_GREEN_EN.

Ports:
- clk, in, 1: clock; all logic on rising edge.
- rst, in, 1: synchronous, active-high reset.
- loop_raw, in, 1: asynchronous raw loop-detector level, 1 = vehicle over loop.
- highway, in, 2: controller highway light; red=00, yellow=01, green=10, 11 illegal.
- country_road, in, 2: controller country-road light; same encoding.
- x, out, 1: registered vehicle-waiting request to the controller.
- queue_count, out, QW: registered count of waiting vehicles.
- conflict, out, 1: sticky registered illegal-light flag.

Behaviour:
- Reset:
  - State IDLE; x=0, queue_count=0, conflict=0.
  - Sync flops, debounced level, stability counter, departure timer and green timer all 0.
  - Reset mid-operation discards the queue; no requests are retained.
- Input path:
  - loop_raw passes through a 2-flop synchronizer.
  - The stability counter increments each cycle the synchronizer output ≠ debounced level, and clears to 0 when they match.
  - On reaching DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Arrival:
  - An arrival is a debounced 0→1 transition, registered as a 1-cycle pulse.
  - queue_count increments the cycle after the pulse.
  - End to end, queue_count increments exactly DEBOUNCE_CYCLES+3 edges after the first edge sampling loop_raw=1.
- Departure:
  - The departure timer counts only while state=SERVE and country_road=10.
  - When it reaches DEPART_CYCLES-1 it wraps to 0 and issues a departure if queue_count>0.
  - The timer clears whenever country_road≠10.
- Queue arithmetic:
  - Arrival and departure in the same cycle: count unchanged.
  - Arrival at 2^QW-1: saturates, no wrap.
  - Departure at 0: no underflow.
- State machine (x is registered, decoded from next state):
  - IDLE (x=0):
    - queue_count>0 → WAIT.
  - WAIT (x=1):
    - country_road=10 → SERVE.
  - SERVE (x=1):
    - queue reaching 0 via departure → HOLDOFF; x=0 the same edge the count reaches 0.
    - country_road leaving 10 with queue>0 → WAIT.
  - HOLDOFF (x=0):
    - Holds until country_road=00 and highway≠00.
    - Then → WAIT if queue_count>0, else IDLE.
    - Arrivals are still counted.
    - Purpose: no re-request glitch during country yellow.
- Conflict:
  - Set when highway≠00 and country_road≠00 simultaneously, or either input = 11.
  - Cleared only by rst.
  - While set: x forced 0, departures suppressed, arrivals still counted, state held.
- No combinational path from any input to any output.

Optional Feature:
- Macro: CR_MAX_GREEN_EN.
- Defined:
  - A green timer counts SERVE cycles with country_road=10 and clears on leaving SERVE.
  - On reaching MAX_GREEN_CYCLES, the FSM goes to HOLDOFF with x=0 even if queue_count>0, so the highway gets served.
  - The normal HOLDOFF exit then re-requests.
- Undefined:
  - No green timer logic; the MAX_GREEN_CYCLES parameter is unused.
  - Country green persists as long as vehicles remain.

Test Plan:
- loop_raw high 10 cycles, lights highway=10/country_road=00, defaults → queue_count 0→1 exactly 7 edges after the first high sample; x=1 on the following edge; a 3-cycle pulse gives no count.
- Queue=2, then country_road=10 → decrements at green cycles 3 and 6; x falls to 0 with count 0; state HOLDOFF until country_road=00 and highway=10, then IDLE.
- Arrival debounced on the same cycle as a departure with queue=1 → queue_count stays 1, x stays 1.
- 17 arrivals, QW=4 → queue_count saturates at 15.
- highway=10 and country_road=01 for one cycle → conflict=1 next edge, x=0; persists after lights legalize; clears only on rst.
- CR_MAX_GREEN_EN, queue=15, country green held → x=0 at green cycle 16 with queue_count=10; on return to country red x reasserts.
